// File: rtl/fir_i2s_pkg.sv
// rtl/fir_i2s_pkg.sv - slot geometry and data offset shared by the I2S transmitter
// LEFT_JUSTIFIED_EN selects a data offset of 0 (left-justified) instead of 1 (I2S).
package fir_i2s_pkg;

    localparam int SLOTS_PER_FRAME = 64;
    localparam int SLOTS_PER_CH    = 32;

`ifdef LEFT_JUSTIFIED_EN
    localparam int DATA_OFFSET = 0;
`else
    localparam int DATA_OFFSET = 1;
`endif

endpackage

// File: rtl/fir_i2s_tx_fifo.sv
// rtl/fir_i2s_tx_fifo.sv - synchronous FIFO between the FIR output and the I2S serialiser
// Ports: clk, reset (sync, active-high), wr_en/wr_data push, rd_en pop,
//        rd_data head word, full, empty, level (registered occupancy).
module sync_fifo #(
    parameter int DATA_W = 24,
    parameter int DEPTH  = 8
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       wr_en,
    input  logic [DATA_W-1:0]          wr_data,
    input  logic                       rd_en,
    output logic [DATA_W-1:0]          rd_data,
    output logic                       full,
    output logic                       empty,
    output logic [$clog2(DEPTH):0]     level
);

    localparam int AW = $clog2(DEPTH);

    logic [DATA_W-1:0] mem [DEPTH];
    logic [AW-1:0]     wr_ptr;
    logic [AW-1:0]     rd_ptr;
    logic              do_pop;
    logic              do_wr;

    assign full    = (level == (AW+1)'(DEPTH));
    assign empty   = (level == '0);
    assign rd_data = mem[rd_ptr];

    // Pop is resolved first, so a write against a full FIFO that is being
    // popped in the same cycle still lands.
    assign do_pop = rd_en && !empty;
    assign do_wr  = wr_en && (!full || do_pop);

    always_ff @(posedge clk) begin
        if (do_wr) begin
            mem[wr_ptr] <= wr_data;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else begin
            if (do_wr) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            level <= level + (AW+1)'(do_wr) - (AW+1)'(do_pop);
        end
    end

endmodule

// File: rtl/fir_i2s_tx.sv
// rtl/fir_i2s_tx.sv - FIFO-buffered mono-to-stereo I2S transmitter with internal bclk/lrclk
// Ports: clk, reset (sync, active-high), din/din_valid sample input, clr_flags,
//        bclk, lrclk (0 = left), sdata (MSB first), fifo_level, overflow, underrun.
// Build option: LEFT_JUSTIFIED_EN switches the frame to left-justified format.
module fir_i2s_tx
    import fir_i2s_pkg::*;
#(
    parameter int DATA_W     = 24,
    parameter int FIFO_DEPTH = 8,
    parameter int BCLK_DIV   = 2
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic [DATA_W-1:0]             din,
    input  logic                          din_valid,
    output logic                          bclk,
    output logic                          lrclk,
    output logic                          sdata,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
    output logic                          overflow,
    output logic                          underrun,
    input  logic                          clr_flags
);

    localparam int DIV_W = (BCLK_DIV > 1) ? $clog2(BCLK_DIV) : 1;

    logic [DIV_W-1:0]  div_cnt;
    logic [5:0]        slot;
    logic [5:0]        next_slot;
    logic [31:0]       shreg;
    logic [DATA_W-1:0] hold;
    logic [DATA_W-1:0] hold_next;
    logic [DATA_W-1:0] fifo_head;
    logic [31:0]       word32;
    logic              terminal;
    logic              fall_evt;
    logic              frame_wrap;
    logic              load;
    logic              pop;
    logic              fifo_full;
    logic              fifo_empty;
    logic              ov_set;
    logic              ur_set;

    assign terminal   = (div_cnt == DIV_W'(BCLK_DIV - 1));
    // bclk is high right before the toggle, so this toggle is a falling edge
    assign fall_evt   = terminal && bclk;
    assign next_slot  = slot + 6'd1;
    assign frame_wrap = fall_evt && (slot == 6'(SLOTS_PER_FRAME - 1));
    assign load       = fall_evt && ((next_slot == 6'd0) || (next_slot == 6'(SLOTS_PER_CH)));

    assign pop       = frame_wrap && !fifo_empty;
    assign hold_next = pop ? fifo_head : hold;
    // Sample left-aligned in a 32-slot half so shifting out the MSB first
    // automatically trails the word with zero padding.
    assign word32    = 32'(hold_next) << (32 - DATA_W);

    assign ov_set = din_valid && fifo_full && !pop;
    assign ur_set = frame_wrap && fifo_empty;

    sync_fifo #(
        .DATA_W (DATA_W),
        .DEPTH  (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .reset   (reset),
        .wr_en   (din_valid),
        .wr_data (din),
        .rd_en   (frame_wrap),
        .rd_data (fifo_head),
        .full    (fifo_full),
        .empty   (fifo_empty),
        .level   (fifo_level)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            div_cnt  <= '0;
            bclk     <= 1'b0;
            lrclk    <= 1'b1;
            sdata    <= 1'b0;
            slot     <= 6'(SLOTS_PER_FRAME - 1);
            shreg    <= '0;
            hold     <= '0;
            overflow <= 1'b0;
            underrun <= 1'b0;
        end else begin
            if (terminal) begin
                div_cnt <= '0;
                bclk    <= ~bclk;
            end else begin
                div_cnt <= div_cnt + 1'b1;
            end

            if (fall_evt) begin
                slot  <= next_slot;
                lrclk <= next_slot[5];
                if (load) begin
                    if (DATA_OFFSET == 0) begin
                        sdata <= word32[31];
                        shreg <= word32 << 1;
                    end else begin
                        // I2S: the first slot of each half is the one-bclk delay
                        sdata <= 1'b0;
                        shreg <= word32;
                    end
                end else begin
                    sdata <= shreg[31];
                    shreg <= shreg << 1;
                end
            end

            if (pop) begin
                hold <= fifo_head;
            end

            // A set in the same cycle as clr_flags wins
            overflow <= ov_set || (overflow && !clr_flags);
            underrun <= ur_set || (underrun && !clr_flags);
        end
    end

endmodule

// File: tb/tb_fir_i2s_tx.sv
// tb/tb_fir_i2s_tx.sv - self-checking bench for fir_i2s_tx
module tb_fir_i2s_tx;

    localparam int DATA_W     = 24;
    localparam int FIFO_DEPTH = 8;
    localparam int BCLK_DIV   = 2;
    localparam int LVL_W      = $clog2(FIFO_DEPTH) + 1;
    localparam int FR         = 128 * BCLK_DIV;
    localparam int WRAP       = 2 * BCLK_DIV;
`ifdef LEFT_JUSTIFIED_EN
    localparam int OFF = 0;
`else
    localparam int OFF = 1;
`endif
    localparam int SH = 32 - OFF - DATA_W;

    logic              clk = 1'b0;
    logic              reset;
    logic [DATA_W-1:0] din;
    logic              din_valid;
    logic              clr_flags;
    logic              bclk;
    logic              lrclk;
    logic              sdata;
    logic [LVL_W-1:0]  fifo_level;
    logic              overflow;
    logic              underrun;

    always #5 clk = ~clk;

    fir_i2s_tx #(
        .DATA_W     (DATA_W),
        .FIFO_DEPTH (FIFO_DEPTH),
        .BCLK_DIV   (BCLK_DIV)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .din        (din),
        .din_valid  (din_valid),
        .bclk       (bclk),
        .lrclk      (lrclk),
        .sdata      (sdata),
        .fifo_level (fifo_level),
        .overflow   (overflow),
        .underrun   (underrun),
        .clr_flags  (clr_flags)
    );

    typedef struct {
        int nwr;
        int exp_level;
        bit exp_ov;
    } vec_t;

    int  total;
    int  bad;
    bit  done;

    // sample-level reference model
    int                e;
    logic [DATA_W-1:0] mq[$];
    logic [DATA_W-1:0] frames[$];
    logic [DATA_W-1:0] m_hold;
    bit                m_ov;
    bit                m_ur;

    // DAC-side decoder
    bit                prev_bclk;
    logic              cur_lr;
    int                nbits;
    logic [31:0]       bits;
    int                frm_rd;
    bit                have_left;
    logic [DATA_W-1:0] last_left;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            if (bad <= 40)
                $display("FAIL %s: got 0x%0h expected 0x%0h at t=%0t", name, act, exp, $time);
        end
    endtask

    task automatic timeout_fail(input string name);
        total++;
        bad++;
        $display("FAIL %s: wait bound expired at t=%0t", name, $time);
    endtask

    task automatic model_step();
        bit set_ov;
        bit set_ur;
        if (reset) begin
            e = 0;
            mq.delete();
            frames.delete();
            m_hold = '0;
            m_ov = 0;
            m_ur = 0;
        end else begin
            e++;
            set_ov = 0;
            set_ur = 0;
            if ((e % FR) == WRAP) begin
                if (mq.size() > 0) m_hold = mq.pop_front();
                else set_ur = 1;
                frames.push_back(m_hold);
            end
            if (din_valid) begin
                if (mq.size() < FIFO_DEPTH) mq.push_back(din);
                else set_ov = 1;
            end
            m_ov = set_ov || (m_ov && !clr_flags);
            m_ur = set_ur || (m_ur && !clr_flags);
        end
    endtask

    task automatic finalize_word();
        logic [31:0]       mask;
        logic [DATA_W-1:0] word;
        mask = ((32'h1 << DATA_W) - 32'h1) << SH;
        word = DATA_W'(bits >> SH);
        check("pad_bits", bits & ~mask, 0);
        if (cur_lr == 1'b0) begin
            if (frm_rd < frames.size()) begin
                check("left_word", word, frames[frm_rd]);
                last_left = frames[frm_rd];
                frm_rd++;
                have_left = 1;
            end else begin
                timeout_fail("left_no_frame");
            end
        end else if (have_left) begin
            check("right_word", word, last_left);
        end
    endtask

    task automatic monitor_step();
        int slot_exp;
        slot_exp = (63 + e / WRAP) % 64;
        check("bclk", bclk, (e / BCLK_DIV) % 2);
        check("lrclk", lrclk, (slot_exp >= 32) ? 1 : 0);
        check("fifo_level", fifo_level, mq.size());
        check("overflow", overflow, m_ov);
        check("underrun", underrun, m_ur);
        if (reset) begin
            prev_bclk = 0;
            cur_lr    = 1'b1;
            nbits     = 0;
            frm_rd    = 0;
            have_left = 0;
        end else begin
            if (bclk && !prev_bclk) begin
                if (lrclk != cur_lr) begin
                    nbits  = 0;
                    cur_lr = lrclk;
                end
                if (nbits < 32) begin
                    bits[31-nbits] = sdata;
                    nbits++;
                    if (nbits == 32) finalize_word();
                end
            end
            prev_bclk = bclk;
        end
    endtask

    task automatic wait_off(input int off);
        int n;
        int target;
        n = 0;
        target = (((WRAP + off) % FR) + FR) % FR;
        while ((e % FR) != target && n < 2 * FR) begin
            @(negedge clk);
            n++;
        end
        if (n >= 2 * FR) timeout_fail("wait_off");
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (mq.size() != 0 && n < 12 * FR) begin
            @(negedge clk);
            n++;
        end
        if (n >= 12 * FR) timeout_fail("drain");
    endtask

    task automatic send(input logic [DATA_W-1:0] v);
        din       = v;
        din_valid = 1'b1;
        @(negedge clk);
        din_valid = 1'b0;
    endtask

    task automatic pulse_clr();
        clr_flags = 1'b1;
        @(negedge clk);
        clr_flags = 1'b0;
    endtask

    task automatic check_reset_state(input string tag);
        check({tag, "_bclk"}, bclk, 0);
        check({tag, "_lrclk"}, lrclk, 1);
        check({tag, "_sdata"}, sdata, 0);
        check({tag, "_level"}, fifo_level, 0);
        check({tag, "_ovf"}, overflow, 0);
        check({tag, "_urun"}, underrun, 0);
    endtask

    initial begin
        vec_t vecs[5];
        reset     = 1'b1;
        din       = '0;
        din_valid = 1'b0;
        clr_flags = 1'b0;
        total     = 0;
        bad       = 0;
        done      = 0;
        e         = 0;
        m_hold    = '0;
        m_ov      = 0;
        m_ur      = 0;
        prev_bclk = 0;
        cur_lr    = 1'b1;
        nbits     = 0;
        bits      = '0;
        frm_rd    = 0;
        have_left = 0;
        last_left = '0;

        vecs[0] = '{nwr: 1,  exp_level: 1, exp_ov: 0};
        vecs[1] = '{nwr: 8,  exp_level: 8, exp_ov: 0};
        vecs[2] = '{nwr: 9,  exp_level: 8, exp_ov: 1};
        vecs[3] = '{nwr: 12, exp_level: 8, exp_ov: 1};
        vecs[4] = '{nwr: 3,  exp_level: 3, exp_ov: 0};

        fork
            begin
                repeat (3) @(negedge clk);
                check_reset_state("rst");
                reset = 1'b0;

                repeat (2 * FR) @(negedge clk);
                check("idle_underrun", underrun, 1);

                wait_off(2);
                send(24'h800001);
                repeat (2 * FR) @(negedge clk);

                for (int i = 0; i < 5; i++) begin
                    drain();
                    wait_off(2);
                    pulse_clr();
                    for (int k = 0; k < vecs[i].nwr; k++) send(DATA_W'($urandom));
                    check($sformatf("vec%0d_level", i), fifo_level, vecs[i].exp_level);
                    check($sformatf("vec%0d_ovf", i), overflow, vecs[i].exp_ov);
                end

                drain();
                wait_off(2);
                pulse_clr();
                repeat (8) send(DATA_W'($urandom));
                wait_off(-1);
                din       = DATA_W'($urandom);
                din_valid = 1'b1;
                @(negedge clk);
                din_valid = 1'b0;
                check("coll_level", fifo_level, 8);
                check("coll_ovf", overflow, 0);

                drain();
                wait_off(2);
                send(24'h123456);
                repeat (3 * FR) @(negedge clk);
                check("rep_underrun", underrun, 1);
                wait_off(10);
                pulse_clr();
                check("rep_cleared", underrun, 0);
                wait_off(3);
                check("rep_underrun_again", underrun, 1);

                for (int i = 0; i < 20 * FR; i++) begin
                    din       = DATA_W'($urandom);
                    din_valid = (i < 10 * FR) ? ($urandom_range(0, 199) == 0)
                                              : ($urandom_range(0, 79) == 0);
                    clr_flags = ($urandom_range(0, 999) == 0);
                    @(negedge clk);
                end
                din_valid = 1'b0;
                clr_flags = 1'b0;

                wait_off(FR / 2);
                reset = 1'b1;
                repeat (2) @(negedge clk);
                check_reset_state("midrst");
                reset = 1'b0;
                wait_off(2);
                send(DATA_W'($urandom));
                repeat (2 * FR) @(negedge clk);
                done = 1;
            end
            begin
                while (!done) begin
                    @(posedge clk);
                    model_step();
                end
            end
            begin
                while (!done) begin
                    @(negedge clk);
                    monitor_step();
                end
            end
        join

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
